bs_drvr_fifo_if: RTL and testbench
==================================

# bs_drvr_fifo_if

Per-driver endpoint buffering between a host agent and the parallel bus generator/arbiter. It holds a TX FIFO that presents pending words to the arbiter (pndng / pop / D_pop) and an RX FIFO that absorbs words the bus delivers (push / D_push). One instance per driver per bus. It keeps the arbiter free of back-pressure on the receive side and latches sticky error flags on protocol violations.

## Interface
- bits, 32: data word width, both directions
- depth, 8: entries per FIFO, any value ≥ 2; counters are $clog2(depth+1) bits wide (CW)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- host_wr  in  1  host writes host_D_in into TX FIFO
- host_D_in  in  bits  TX write data
- tx_full  out  1  TX FIFO holds depth words
- tx_count  out  CW  TX occupancy
- pndng  out  1  TX FIFO non-empty; goes to arbiter pndng
- pop  in  1  arbiter removes TX head
- D_pop  out  bits  TX head word (first-word fall-through); 0 when empty
- push  in  1  arbiter delivers D_push into RX FIFO
- D_push  in  bits  RX write data from bus
- host_rd  in  1  host removes RX head
- host_D_out  out  bits  RX head word (FWFT); 0 when empty
- rx_pndng  out  1  RX FIFO non-empty
- rx_full  out  1  RX FIFO holds depth words
- err_clr  in  1  clears the sticky error flags
- tx_ovrflw  out  1  sticky: host_wr while TX full without same-cycle pop
- tx_undrflw  out  1  sticky: pop while TX empty
- rx_ovrflw  out  1  sticky: push while RX full without same-cycle host_rd

## Operation
- Both FIFOs are identical circular buffers: rd_ptr, wr_ptr (0..depth-1, wrap from depth-1 to 0 also for non-power-of-2 depth), count 0..depth.
- Write accepted when count < depth, or count == depth with a same-cycle read that is accepted. Otherwise the word is dropped, pointers do not move, and the overflow flag is set.
- Read accepted when count > 0. A read on an empty FIFO is ignored and sets tx_undrflw (TX side). A host_rd on an empty RX FIFO is ignored silently.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- Empty plus simultaneous write and read: the write is accepted, the read is ignored, count becomes 1, and the TX side sets tx_undrflw.
- Head data is read combinationally from storage[rd_ptr] and gated to 0 when count == 0.
- Status is decoded from the registered count: pndng/rx_pndng = (count != 0), full = (count == depth).
- Error flags are set on the violating edge and held until reset or err_clr. If err_clr and a new violation occur in the same cycle, the set wins.
- Data integrity: words leave each FIFO in write order, unmodified. The block performs no address or broadcast interpretation.

## Timing
- Reset (synchronous): after the first rising edge with reset=1, all pointers, counts, and flags are 0, so pndng=0, rx_pndng=0, tx_full=0, rx_full=0, D_pop=0, host_D_out=0. Storage contents are don't-care. Reset overrides any same-cycle wr/rd/push/pop. A reset asserted mid-stream discards all buffered words.
- Write-to-visible latency is 1 cycle. A write at edge N gives pndng=1 and the word on D_pop after edge N.
- Pop at edge N: the next word, or 0 with pndng=0, appears after edge N. The arbiter may pop on consecutive cycles while pndng=1, for one word per cycle sustained throughput.
- A full FIFO with a read every cycle accepts a write every cycle, with no bubble.
- All outputs are registered-state decodes only. No combinational path runs from pop, push, host_wr, or host_rd to any output.

## Test plan
- Reset/fill: depth=4. After reset, write 0xA0..0xA3 on consecutive cycles. Expect tx_count 1,2,3,4, tx_full=1 after the 4th, D_pop=0xA0, pndng=1.
- Drain order: from that full state, pop 4 consecutive cycles. Expect D_pop 0xA0,0xA1,0xA2,0xA3, then 0, with pndng=0 and tx_undrflw=0.
- Overflow/undrflw: with TX full, host_wr 0xBB. Expect the word dropped and tx_ovrflw=1. Drain, then pop once more: tx_undrflw=1. err_clr: both flags 0 next cycle.
- Full with simultaneous ops: TX full, host_wr 0xCC together with pop. Expect tx_count stays 4, tx_ovrflw stays 0, and 0xCC emerges as the 4th word after 3 further pops.
- Wrap-around: depth=5. Push 13 words 0x100..0x10C into RX interleaved with host_rd so occupancy stays 1..3. Expect host_D_out sequence identical and in order, rx_ovrflw=0.
- Reset mid-operation: RX holds 3 words and push is asserted with reset. Expect rx_pndng=0, host_D_out=0, rx_ovrflw=0 next cycle, and the pushed word discarded.

Source files
------------

// File: rtl/bs_drvr_fifo_if.sv
// Per-driver bus endpoint: TX FIFO toward the arbiter, RX FIFO from the bus, sticky error flags.
// One-cycle write-to-visible latency; a full FIFO accepts a write only alongside a read, else the word is dropped.

module bs_fifo #(
  parameter int width = 32,
  parameter int depth = 8,
  localparam int CW = $clog2(depth + 1),
  localparam int PW = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wr_dat,
  input  logic             rd,
  output logic [width-1:0] rd_dat,
  output logic [CW-1:0]    count,
  output logic             ovrflw
);
  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             rd_ok, wr_ok;

  // A full FIFO can still take a write when the same-cycle read frees a slot.
  assign rd_ok  = rd && (count != '0);
  assign wr_ok  = wr && ((count != CW'(depth)) || rd_ok);
  assign ovrflw = wr && !wr_ok;
  assign rd_dat = (count != '0) ? mem[rd_ptr] : '0;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (rd_ok) rd_ptr <= nxt(rd_ptr);
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

module bs_drvr_fifo_if #(
  parameter int bits  = 32,
  parameter int depth = 8,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            host_wr,
  input  logic [bits-1:0] host_D_in,
  output logic            tx_full,
  output logic [CW-1:0]   tx_count,
  output logic            pndng,
  input  logic            pop,
  output logic [bits-1:0] D_pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  input  logic            host_rd,
  output logic [bits-1:0] host_D_out,
  output logic            rx_pndng,
  output logic            rx_full,
  input  logic            err_clr,
  output logic            tx_ovrflw,
  output logic            tx_undrflw,
  output logic            rx_ovrflw
);
  logic [CW-1:0] rx_count;
  logic          tx_ovr_evt, rx_ovr_evt;

  bs_fifo #(.width(bits), .depth(depth)) u_tx (
    .clk(clk), .reset(reset), .wr(host_wr), .wr_dat(host_D_in),
    .rd(pop), .rd_dat(D_pop), .count(tx_count), .ovrflw(tx_ovr_evt)
  );

  bs_fifo #(.width(bits), .depth(depth)) u_rx (
    .clk(clk), .reset(reset), .wr(push), .wr_dat(D_push),
    .rd(host_rd), .rd_dat(host_D_out), .count(rx_count), .ovrflw(rx_ovr_evt)
  );

  assign pndng    = (tx_count != '0);
  assign tx_full  = (tx_count == CW'(depth));
  assign rx_pndng = (rx_count != '0);
  assign rx_full  = (rx_count == CW'(depth));

  // A new violation wins over a same-cycle err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovrflw  <= 1'b0;
      tx_undrflw <= 1'b0;
      rx_ovrflw  <= 1'b0;
    end else begin
      tx_ovrflw  <= (tx_ovrflw && !err_clr) || tx_ovr_evt;
      tx_undrflw <= (tx_undrflw && !err_clr) || (pop && (tx_count == '0));
      rx_ovrflw  <= (rx_ovrflw && !err_clr) || rx_ovr_evt;
    end
  end
endmodule

// File: tb/tb_bs_drvr_fifo_if.sv
// Two instances (depth 4 and depth 5) checked against a queue-based reference model.
module tb_bs_drvr_fifo_if;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset[2], host_wr[2], pop[2], push[2], host_rd[2], err_clr[2];
  logic [31:0] host_D_in[2], D_push[2], D_pop[2], host_D_out[2];
  logic        tx_full[2], pndng[2], rx_pndng[2], rx_full[2];
  logic        tx_ovrflw[2], tx_undrflw[2], rx_ovrflw[2];
  logic [2:0]  tx_count[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bs_drvr_fifo_if #(.bits(32), .depth(g == 0 ? 4 : 5)) dut (
      .clk(clk), .reset(reset[g]),
      .host_wr(host_wr[g]), .host_D_in(host_D_in[g]),
      .tx_full(tx_full[g]), .tx_count(tx_count[g]), .pndng(pndng[g]),
      .pop(pop[g]), .D_pop(D_pop[g]),
      .push(push[g]), .D_push(D_push[g]),
      .host_rd(host_rd[g]), .host_D_out(host_D_out[g]),
      .rx_pndng(rx_pndng[g]), .rx_full(rx_full[g]),
      .err_clr(err_clr[g]),
      .tx_ovrflw(tx_ovrflw[g]), .tx_undrflw(tx_undrflw[g]), .rx_ovrflw(rx_ovrflw[g])
    );
  end

  int checks = 0;
  int errors = 0;

  int          dep[2] = '{4, 5};
  logic [31:0] tq[2][$];
  logic [31:0] rq[2][$];
  logic        m_txo[2], m_txu[2], m_rxo[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      reset[k] = 0; host_wr[k] = 0; pop[k] = 0; push[k] = 0; host_rd[k] = 0; err_clr[k] = 0;
      host_D_in[k] = '0; D_push[k] = '0;
    end
  endtask

  // Reference: each FIFO is an ordered queue of at most dep[k] words.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit pok, wok, rok, sok;
      if (reset[k]) begin
        tq[k].delete(); rq[k].delete();
        m_txo[k] = 0; m_txu[k] = 0; m_rxo[k] = 0;
      end else begin
        pok = pop[k] && tq[k].size() > 0;
        wok = host_wr[k] && (tq[k].size() < dep[k] || pok);
        rok = host_rd[k] && rq[k].size() > 0;
        sok = push[k] && (rq[k].size() < dep[k] || rok);
        m_txu[k] = (m_txu[k] && !err_clr[k]) || (pop[k] && tq[k].size() == 0);
        m_txo[k] = (m_txo[k] && !err_clr[k]) || (host_wr[k] && !wok);
        m_rxo[k] = (m_rxo[k] && !err_clr[k]) || (push[k] && !sok);
        if (pok) void'(tq[k].pop_front());
        if (wok) tq[k].push_back(host_D_in[k]);
        if (rok) void'(rq[k].pop_front());
        if (sok) rq[k].push_back(D_push[k]);
      end
    end
  endtask

  task automatic verify();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d_tx_count", k), 32'(tx_count[k]), 32'(tq[k].size()));
      chk($sformatf("i%0d_tx_full", k), 32'(tx_full[k]), 32'(tq[k].size() == dep[k]));
      chk($sformatf("i%0d_pndng", k), 32'(pndng[k]), 32'(tq[k].size() != 0));
      chk($sformatf("i%0d_D_pop", k), D_pop[k], tq[k].size() != 0 ? tq[k][0] : 32'h0);
      chk($sformatf("i%0d_rx_pndng", k), 32'(rx_pndng[k]), 32'(rq[k].size() != 0));
      chk($sformatf("i%0d_rx_full", k), 32'(rx_full[k]), 32'(rq[k].size() == dep[k]));
      chk($sformatf("i%0d_host_D_out", k), host_D_out[k], rq[k].size() != 0 ? rq[k][0] : 32'h0);
      chk($sformatf("i%0d_tx_ovrflw", k), 32'(tx_ovrflw[k]), 32'(m_txo[k]));
      chk($sformatf("i%0d_tx_undrflw", k), 32'(tx_undrflw[k]), 32'(m_txu[k]));
      chk($sformatf("i%0d_rx_ovrflw", k), 32'(rx_ovrflw[k]), 32'(m_rxo[k]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    verify();
    idle();
  endtask

  task automatic fill_tx0();
    for (int i = 0; i < 4; i++) begin
      host_wr[0] = 1; host_D_in[0] = 32'hA0 + 32'(i);
      tick();
      chk("fill_count", 32'(tx_count[0]), 32'(i + 1));
    end
  endtask

  initial begin
    int rd_idx;
    idle();
    reset[0] = 1; reset[1] = 1;
    tick();
    chk("rst_pndng", 32'(pndng[0]), 0);
    chk("rst_D_pop", D_pop[0], 0);
    chk("rst_host_D_out", host_D_out[1], 0);

    fill_tx0();
    chk("fill_full", 32'(tx_full[0]), 1);
    chk("fill_head", D_pop[0], 32'hA0);
    chk("fill_pndng", 32'(pndng[0]), 1);

    for (int i = 0; i < 4; i++) begin
      chk("drain_head", D_pop[0], 32'hA0 + 32'(i));
      pop[0] = 1;
      tick();
    end
    chk("drain_empty_dat", D_pop[0], 0);
    chk("drain_pndng", 32'(pndng[0]), 0);
    chk("drain_undrflw", 32'(tx_undrflw[0]), 0);

    fill_tx0();
    host_wr[0] = 1; host_D_in[0] = 32'hBB;
    tick();
    chk("ovf_flag", 32'(tx_ovrflw[0]), 1);
    chk("ovf_count", 32'(tx_count[0]), 4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", D_pop[0], 32'hA0 + 32'(i));
      pop[0] = 1;
      tick();
    end
    pop[0] = 1;
    tick();
    chk("udf_flag", 32'(tx_undrflw[0]), 1);
    err_clr[0] = 1;
    tick();
    chk("clr_ovf", 32'(tx_ovrflw[0]), 0);
    chk("clr_udf", 32'(tx_undrflw[0]), 0);

    fill_tx0();
    host_wr[0] = 1; host_D_in[0] = 32'hCC; pop[0] = 1;
    tick();
    chk("simul_count", 32'(tx_count[0]), 4);
    chk("simul_ovf", 32'(tx_ovrflw[0]), 0);
    for (int i = 0; i < 3; i++) begin pop[0] = 1; tick(); end
    chk("simul_cc", D_pop[0], 32'hCC);
    pop[0] = 1;
    tick();

    rd_idx = 0;
    for (int i = 0; i < 13; i++) begin
      push[1] = 1; D_push[1] = 32'h100 + 32'(i);
      if (i >= 2) begin
        chk("wrap_order", host_D_out[1], 32'h100 + 32'(rd_idx));
        host_rd[1] = 1; rd_idx++;
      end
      tick();
    end
    while (rd_idx < 13) begin
      chk("wrap_order", host_D_out[1], 32'h100 + 32'(rd_idx));
      host_rd[1] = 1; rd_idx++;
      tick();
    end
    chk("wrap_ovf", 32'(rx_ovrflw[1]), 0);
    chk("wrap_empty", 32'(rx_pndng[1]), 0);

    for (int i = 0; i < 3; i++) begin push[1] = 1; D_push[1] = 32'h200 + 32'(i); tick(); end
    push[1] = 1; D_push[1] = 32'h1FF; reset[1] = 1;
    tick();
    chk("mrst_pndng", 32'(rx_pndng[1]), 0);
    chk("mrst_dat", host_D_out[1], 0);
    chk("mrst_ovf", 32'(rx_ovrflw[1]), 0);
    tick();
    chk("mrst_discard", 32'(rx_pndng[1]), 0);

    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        host_wr[k]   = ($urandom % 3) != 0;
        pop[k]       = ($urandom % 2) == 0;
        push[k]      = ($urandom % 3) != 0;
        host_rd[k]   = ($urandom % 2) == 0;
        err_clr[k]   = ($urandom % 16) == 0;
        reset[k]     = ($urandom % 97) == 0;
        host_D_in[k] = $urandom;
        D_push[k]    = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
